pipeline_sink_responder: RTL and testbench

Clocked termination for the right end of an asynchronous controller pipeline. It plays the receiver role on the 4-phase request/acknowledge channel (Rreq in, Rack out) and the initiator role on the backward error channel (REreq out, REack in). It gives synchronous benches and the SoC side a deterministic token sink, with optional error injection and cycle-time and token-count measurement.

---
 rtl/pipeline_sink_responder.sv | 185 ++++++++++++++++++
 tb/tb_pipeline_sink_responder.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sink_responder.sv
// Purpose: clocked 4-phase receiver at the right end of an async pipeline, plus initiator on the backward error channel.
// Latency: Rack rises SYNC_STAGES+ACK_DELAY+2 clk edges after Rreq is first sampled high (longer when an error handshake runs first).
// Backpressure: Rack is withheld through HOLD and any error handshake; the next token is refused until Rreq and Rack have both returned to zero.
module pipeline_sink_responder #(
    parameter int SYNC_STAGES = 2,   // at least 2
    parameter int ACK_DELAY   = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Rreq,
    output logic             Rack,
    output logic             REreq,
    input  logic             REack,
    input  logic             err_inject,
    output logic             err_pending,
    output logic             busy,
    output logic [CNT_W-1:0] token_count,
    output logic [CNT_W-1:0] cycle_time,
    output logic             cycle_valid
);

    localparam int DLY_W = (ACK_DELAY < 2) ? 1 : $clog2(ACK_DELAY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR_REQ,
        S_ERR_REL,
        S_HOLD,
        S_ACK_HI,
        S_ACK_LO
    } state_t;

    logic [SYNC_STAGES-1:0] rreq_sync_q;
    logic [SYNC_STAGES-1:0] reack_sync_q;
    logic                   rreq_s;
    logic                   reack_s;

    state_t                 state_q;
    logic [DLY_W-1:0]       dly_q;
    logic                   rack_q;
    logic                   rereq_q;
    logic [CNT_W-1:0]       tok_q;

    logic                   err_q;
    logic                   err_d;
    logic                   err_clr;
    logic                   accept;

    logic [CNT_W-1:0]       cyc_cnt_q;
    logic [CNT_W-1:0]       cyc_cnt_d;
    logic [CNT_W-1:0]       cycle_time_q;
    logic                   cycle_valid_q;
    logic                   seen_q;

    assign rreq_s  = rreq_sync_q[SYNC_STAGES-1];
    assign reack_s = reack_sync_q[SYNC_STAGES-1];

    // Accept event: the idle FSM sees a new request; the error latch clears once the pipeline acknowledges the error.
    assign accept  = (state_q == S_IDLE) && rreq_s;
    assign err_clr = (state_q == S_ERR_REQ) && reack_s;

    // Multi-flop synchronizers for the two asynchronous inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rreq_sync_q  <= '0;
            reack_sync_q <= '0;
        end else begin
            rreq_sync_q  <= {rreq_sync_q[SYNC_STAGES-2:0], Rreq};
            reack_sync_q <= {reack_sync_q[SYNC_STAGES-2:0], REack};
        end
    end

    // Handshake FSM; Rack/REreq are registered alongside the state so they never glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            dly_q   <= '0;
            rack_q  <= 1'b0;
            rereq_q <= 1'b0;
            tok_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rreq_s) begin
                        dly_q <= '0;
                        if (err_q) begin
                            state_q <= S_ERR_REQ;
                            rereq_q <= 1'b1;
                        end else begin
                            state_q <= S_HOLD;
                        end
                    end
                end
                S_ERR_REQ: begin
                    if (reack_s) begin
                        state_q <= S_ERR_REL;
                        rereq_q <= 1'b0;
                    end
                end
                S_ERR_REL: begin
                    if (!reack_s) begin
                        state_q <= S_HOLD;
                        dly_q   <= '0;
                    end
                end
                S_HOLD: begin
                    // One cycle even with zero delay, then ACK_DELAY more.
                    if (dly_q == DLY_W'(ACK_DELAY)) begin
                        state_q <= S_ACK_HI;
                        rack_q  <= 1'b1;
                        tok_q   <= tok_q + CNT_W'(1);
                    end else begin
                        dly_q <= dly_q + DLY_W'(1);
                    end
                end
                S_ACK_HI: begin
                    if (!rreq_s) begin
                        state_q <= S_ACK_LO;
                        rack_q  <= 1'b0;
                    end
                end
                S_ACK_LO: begin
                    // Return-to-zero cycle before another token may be accepted.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    rack_q  <= 1'b0;
                    rereq_q <= 1'b0;
                end
            endcase
        end
    end

    // Error latch next state: a new injection wins over a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (err_inject) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // Interval counter next state: restart at 1 on accept, otherwise count up and stick at all-ones.
    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if (accept) begin
            cyc_cnt_d = CNT_W'(1);
        end else if (cyc_cnt_q != '1) begin
            cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end
    end

    // Error latch and cycle-time measurement registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q         <= 1'b0;
            cyc_cnt_q     <= '0;
            cycle_time_q  <= '0;
            cycle_valid_q <= 1'b0;
            seen_q        <= 1'b0;
        end else begin
            err_q     <= err_d;
            cyc_cnt_q <= cyc_cnt_d;
            if (accept) begin
                seen_q <= 1'b1;
                if (seen_q) begin
                    cycle_time_q  <= cyc_cnt_q;
                    cycle_valid_q <= 1'b1;
                end
            end
        end
    end

    assign Rack        = rack_q;
    assign REreq       = rereq_q;
    assign err_pending = err_q;
    assign busy        = (state_q != S_IDLE);
    assign token_count = tok_q;
    assign cycle_time  = cycle_time_q;
    assign cycle_valid = cycle_valid_q;

endmodule

// File: tb/tb_pipeline_sink_responder.sv
// Bench for pipeline_sink_responder: two instances (default widths and CNT_W=4) share one stimulus.
// A cycle-level reference model predicts every output; literal checks pin the model on known scenarios.
// Randomized token gaps, release delays, error injections and REack response times.
module tb_pipeline_sink_responder;

    localparam int S  = 2;
    localparam int D  = 2;
    localparam int WA = 16;
    localparam int WB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic Rreq = 1'b0;
    logic err_inject = 1'b0;
    logic auto_reack = 1'b0;
    logic man_reack = 1'b0;
    logic resp_auto = 1'b0;
    logic REack;

    logic          rack_a, rereq_a, errp_a, busy_a, cv_a;
    logic [WA-1:0] tc_a, ct_a;
    logic          rack_b, rereq_b, errp_b, busy_b, cv_b;
    logic [WB-1:0] tc_b, ct_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_raise;

    assign REack = resp_auto ? auto_reack : man_reack;

    pipeline_sink_responder #(.SYNC_STAGES(S), .ACK_DELAY(D), .CNT_W(WA)) dut_a (
        .clk(clk), .rst(rst), .Rreq(Rreq), .Rack(rack_a), .REreq(rereq_a), .REack(REack),
        .err_inject(err_inject), .err_pending(errp_a), .busy(busy_a),
        .token_count(tc_a), .cycle_time(ct_a), .cycle_valid(cv_a)
    );

    pipeline_sink_responder #(.SYNC_STAGES(S), .ACK_DELAY(D), .CNT_W(WB)) dut_b (
        .clk(clk), .rst(rst), .Rreq(Rreq), .Rack(rack_b), .REreq(rereq_b), .REack(REack),
        .err_inject(err_inject), .err_pending(errp_b), .busy(busy_b),
        .token_count(tc_b), .cycle_time(ct_b), .cycle_valid(cv_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // ---------------- reference model ----------------
    // Phases of one token's life as seen by the sink.
    localparam int P_IDLE = 0, P_EUP = 1, P_EDN = 2, P_WAIT = 3, P_ACK = 4, P_RTZ = 5;

    int m_ph = P_IDLE;
    int m_left = 0;
    int m_tokens = 0;
    int m_edge = 0;
    int m_last_acc = 0;
    int m_diff = 0;
    bit m_have_acc = 0;
    bit m_cv = 0;
    bit m_err = 0;
    bit m_rs [S];
    bit m_es [S];

    always @(posedge clk or negedge rst) begin : model
        bit rs, ea, clr;
        if (!rst) begin
            m_ph = P_IDLE; m_left = 0; m_tokens = 0; m_edge = 0; m_last_acc = 0;
            m_diff = 0; m_have_acc = 0; m_cv = 0; m_err = 0;
            for (int i = 0; i < S; i++) begin m_rs[i] = 0; m_es[i] = 0; end
        end else begin
            rs = m_rs[S-1];
            ea = m_es[S-1];
            clr = 0;
            for (int i = S - 1; i > 0; i--) begin m_rs[i] = m_rs[i-1]; m_es[i] = m_es[i-1]; end
            m_rs[0] = Rreq;
            m_es[0] = REack;
            m_edge++;
            case (m_ph)
                P_IDLE: if (rs) begin
                    if (m_have_acc) begin m_diff = m_edge - m_last_acc; m_cv = 1; end
                    m_have_acc = 1;
                    m_last_acc = m_edge;
                    m_left = D;
                    m_ph = m_err ? P_EUP : P_WAIT;
                end
                P_EUP: if (ea) begin m_ph = P_EDN; clr = 1; end
                P_EDN: if (!ea) begin m_ph = P_WAIT; m_left = D; end
                P_WAIT: if (m_left == 0) begin m_ph = P_ACK; m_tokens++; end else m_left--;
                P_ACK: if (!rs) m_ph = P_RTZ;
                default: m_ph = P_IDLE;
            endcase
            m_err = err_inject | (m_err & !clr);
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin : cmp
        logic [36:0] exp_a, act_a;
        logic [12:0] exp_b, act_b;
        int cta, ctb;
        cta = m_cv ? ((m_diff > 65535) ? 65535 : m_diff) : 0;
        ctb = m_cv ? ((m_diff > 15) ? 15 : m_diff) : 0;
        exp_a = {m_ph == P_ACK, m_ph == P_EUP, m_ph != P_IDLE, m_err, m_cv, 16'(m_tokens), 16'(cta)};
        act_a = {rack_a, rereq_a, busy_a, errp_a, cv_a, tc_a, ct_a};
        exp_b = {m_ph == P_ACK, m_ph == P_EUP, m_ph != P_IDLE, m_err, m_cv, 4'(m_tokens), 4'(ctb)};
        act_b = {rack_b, rereq_b, busy_b, errp_b, cv_b, tc_b, ct_b};
        n_checks += 3;
        if (act_a !== exp_a) begin
            n_fail++;
            $display("FAIL model_a t=%0t: got %h expected %h", $time, act_a, exp_a);
        end
        if (act_b !== exp_b) begin
            n_fail++;
            $display("FAIL model_b t=%0t: got %h expected %h", $time, act_b, exp_b);
        end
        if (rack_a && rereq_a) begin
            n_fail++;
            $display("FAIL rack_rereq_exclusive t=%0t: got both 1 expected not both", $time);
        end
    end

    // Automatic REack responder with random latency.
    initial begin : responder
        int resp_wait;
        resp_wait = 0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_reack != rereq_a) begin
                if (resp_wait == 0) begin
                    auto_reack = rereq_a;
                    resp_wait = $urandom_range(0, 3);
                end else begin
                    resp_wait--;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit sig(input int which);
        case (which)
            0: return rack_a;
            1: return rereq_a;
            default: return busy_a;
        endcase
    endfunction

    task automatic wait_for(input string name, input int which, input bit val, input int budget);
        int n;
        n = 0;
        while (sig(which) != val && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (sig(which) != val) begin
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles, got %0d expected %0d", name, n, sig(which), val);
        end
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
    endtask

    task automatic finish_token(input int drop_delay);
        wait_for("rack_rise", 0, 1'b1, 200);
        repeat (drop_delay) tick();
        Rreq = 1'b0;
        wait_for("rack_fall", 0, 1'b0, 50);
        wait_for("busy_fall", 2, 1'b0, 50);
    endtask

    task automatic raise_at(input int period);
        while (cyc - last_raise < period) tick();
        last_raise = cyc;
        Rreq = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        bit r [1:6];
        bit b [1:6];

        #1 rst = 1'b0;
        #69 rst = 1'b1;

        // Test 1: reset state and default latency.
        check("reset_rack", rack_a, 0);
        check("reset_busy", busy_a, 0);
        check("reset_token_count", tc_a, 0);
        check("reset_cycle_valid", cv_a, 0);
        tick();
        Rreq = 1'b1;
        for (int e = 1; e <= 6; e++) begin tick(); r[e] = rack_a; b[e] = busy_a; end
        check("t1_busy_e2", b[2], 0);
        check("t1_busy_e3", b[3], 1);
        check("t1_rack_e5", r[5], 0);
        check("t1_rack_e6", r[6], 1);
        check("t1_token_count", tc_a, 1);
        Rreq = 1'b0;
        for (int e = 1; e <= 4; e++) begin tick(); r[e] = rack_a; b[e] = busy_a; end
        check("t1_rack_fall_e2", r[2], 1);
        check("t1_rack_fall_e3", r[3], 0);
        check("t1_busy_fall_e3", b[3], 1);
        check("t1_busy_fall_e4", b[4], 0);

        // Test 2: one error handshake before the ack.
        do_reset();
        resp_auto = 1'b0;
        man_reack = 1'b0;
        err_inject = 1'b1;
        tick();
        err_inject = 1'b0;
        check("t2_err_pending_set", errp_a, 1);
        Rreq = 1'b1;
        for (int e = 1; e <= 3; e++) begin tick(); r[e] = rereq_a; end
        check("t2_rereq_e2", r[2], 0);
        check("t2_rereq_e3", r[3], 1);
        check("t2_rack_low", rack_a, 0);
        man_reack = 1'b1;
        for (int e = 1; e <= 3; e++) begin tick(); r[e] = rereq_a; b[e] = errp_a; end
        check("t2_rereq_hold_e2", r[2], 1);
        check("t2_rereq_drop_e3", r[3], 0);
        check("t2_err_pending_e2", b[2], 1);
        check("t2_err_pending_e3", b[3], 0);
        man_reack = 1'b0;
        for (int e = 1; e <= 6; e++) begin tick(); r[e] = rack_a; end
        check("t2_rack_e5", r[5], 0);
        check("t2_rack_e6", r[6], 1);
        check("t2_token_count", tc_a, 1);
        finish_token(0);

        // Test 3: period-20 tokens.
        do_reset();
        resp_auto = 1'b1;
        last_raise = -1000;
        for (int i = 0; i < 10; i++) begin
            raise_at(20);
            finish_token(0);
            if (i == 0) check("t3_cycle_valid_first", cv_a, 0);
            if (i == 1) begin
                check("t3_cycle_valid", cv_a, 1);
                check("t3_cycle_time", ct_a, 20);
                check("t3_cycle_time_sat4", ct_b, 15);
            end
        end
        check("t3_token_count", tc_a, 10);

        // Test 4: narrow counters wrap and saturate.
        for (int i = 0; i < 7; i++) begin
            raise_at(20);
            finish_token(0);
        end
        check("t4_token_count_w16", tc_a, 17);
        check("t4_token_count_w4", tc_b, 1);
        raise_at(40);
        finish_token(0);
        check("t4_cycle_time_w16", ct_a, 40);
        check("t4_cycle_time_w4", ct_b, 15);
        check("t4_model_tokens", m_tokens, 18);
        check("t4_model_diff", m_diff, 40);

        // Test 5: reset in ACK_HI with Rreq still high.
        do_reset();
        Rreq = 1'b1;
        wait_for("t5_rack_rise", 0, 1'b1, 50);
        #2 rst = 1'b0;
        #1;
        check("t5_rack_async", rack_a, 0);
        check("t5_rereq_async", rereq_a, 0);
        check("t5_busy_async", busy_a, 0);
        check("t5_tc_async", tc_a, 0);
        check("t5_tc_b_async", tc_b, 0);
        tick();
        rst = 1'b1;
        for (int e = 1; e <= 6; e++) begin tick(); r[e] = rack_a; end
        check("t5_rack_e5", r[5], 0);
        check("t5_rack_e6", r[6], 1);
        check("t5_token_count", tc_a, 1);
        Rreq = 1'b0;
        wait_for("t5_rack_fall", 0, 1'b0, 50);
        wait_for("t5_busy_fall", 2, 1'b0, 50);

        // Test 6: injection coinciding with the latch clear re-arms for the next token.
        do_reset();
        resp_auto = 1'b0;
        man_reack = 1'b0;
        err_inject = 1'b1;
        tick();
        err_inject = 1'b0;
        Rreq = 1'b1;
        wait_for("t6_rereq_rise", 1, 1'b1, 50);
        man_reack = 1'b1;
        tick();
        tick();
        err_inject = 1'b1;
        tick();
        err_inject = 1'b0;
        check("t6_rereq_released", rereq_a, 0);
        check("t6_err_pending_kept", errp_a, 1);
        man_reack = 1'b0;
        finish_token(0);
        Rreq = 1'b1;
        wait_for("t6_second_rereq", 1, 1'b1, 50);
        check("t6_second_rack_low", rack_a, 0);
        man_reack = 1'b1;
        wait_for("t6_second_rereq_fall", 1, 1'b0, 50);
        check("t6_err_pending_clear", errp_a, 0);
        man_reack = 1'b0;
        finish_token(1);
        check("t6_token_count", tc_a, 2);

        // Randomized traffic with auto responder.
        resp_auto = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 30);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 15) == 0) err_inject = 1'b1;
                tick();
                err_inject = 1'b0;
            end
            Rreq = 1'b1;
            finish_token($urandom_range(0, 3));
        end
        check("rand_token_count", tc_a, 16'(m_tokens));

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
